muldiv_issue_ctrl: RTL
======================

Name: muldiv_issue_ctrl

Overview:
- Sequencer between the core's execute stage and the MULDIV block.
- Accepts one decoded M-extension operation per valid/ready handshake and registers its operands, funct3 and rd.
- Drives MULDIV's start and operands, waits on busy, and presents the result with a valid/ready writeback handshake.
- Replaces core-side polling of busy and handles pipeline flushes while a division is in flight.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): operand/result width.
- RD_WIDTH, 5: destination register index width.
- TIMEOUT_CYCLES, 64: watchdog limit in busy cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rstLow  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  operation request valid.
- req_ready_o  output  1  controller can accept a request.
- req_funct3_i  input  3  M-extension funct3.
- req_rs1_i  input  DATA_WIDTH  rs1 operand.
- req_rs2_i  input  DATA_WIDTH  rs2 operand.
- req_rd_i  input  RD_WIDTH  destination register.
- flush_i  input  1  discard the in-flight operation.
- md_rs1_o  output  DATA_WIDTH  to MULDIV rs1_i.
- md_rs2_o  output  DATA_WIDTH  to MULDIV rs2_i.
- md_funct3_o  output  3  to MULDIV funct3_i.
- md_start_o  output  1  to MULDIV start_i.
- md_busy_i  input  1  from MULDIV busy_o.
- md_c_i  input  DATA_WIDTH  from MULDIV c_o.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  writeback accepts the result.
- rsp_rd_o  output  RD_WIDTH  destination register of the result.
- rsp_data_o  output  DATA_WIDTH  result.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rstLow is asynchronous, active-low.
  - Reset forces state IDLE and clears all registers.
  - Output reset values: req_ready_o=1, md_start_o=0, rsp_valid_o=0; md_* operands, funct3, rsp_rd_o and rsp_data_o are 0.
- States: IDLE, START, WAIT, DONE, DRAIN.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o: latch rs1/rs2/funct3/rd into operand registers, go START.
  - md_* always driven from the operand registers, so they stay stable for the whole operation.
- START: md_start_o=1, req_ready_o=0.
  - If md_busy_i=0 this cycle (MUL* ops, div-by-0, overflow, reused-remainder): capture md_c_i into rsp_data_o, go DONE.
  - Else go WAIT.
- WAIT:
  - md_start_o=0.
  - When md_busy_i=0: capture md_c_i, go DONE.
- DONE:
  - rsp_valid_o=1; rsp_rd_o and rsp_data_o held stable until rsp_ready_i=1.
  - On rsp_ready_i=1 go IDLE; rsp_valid_o drops the next cycle.
  - No back-to-back accept in the same cycle as the response handshake.
- Latency:
  - Single-cycle ops: request accepted at cycle 0, rsp_valid_o at cycle 2.
  - Division: rsp_valid_o 1 cycle after the first cycle with md_busy_i=0 following START.
- flush_i (priority over all other transitions except reset):
  - IDLE: no effect; a request presented that same cycle is not accepted.
  - START with md_busy_i=0: go IDLE, result discarded.
  - START with md_busy_i=1, or WAIT: go DRAIN. MULDIV has no abort, so the divider must finish.
  - DRAIN: md_start_o=0, req_ready_o=0, rsp_valid_o=0; go IDLE when md_busy_i=0, result discarded.
  - DONE: rsp_valid_o drops next cycle, go IDLE.
- md_start_o is high only in START. It is never re-asserted in WAIT or DRAIN, so MULDIV cannot see a second start pulse.
- rsp_data_o is updated only on capture; it holds its value at all other times.

Optional Feature:
- Macro MULDIV_WATCHDOG_EN.
- With the macro:
  - Extra output rsp_err_o (1 bit, resets 0).
  - A busy counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT or DRAIN cycle.
  - When the counter reaches TIMEOUT_CYCLES in WAIT: go DONE with rsp_data_o={DATA_WIDTH{1'b1}} and rsp_err_o=1.
  - When the counter reaches TIMEOUT_CYCLES in DRAIN: go IDLE.
  - rsp_err_o is 0 for normal completions.
- Without the macro: no counter, no rsp_err_o port; WAIT and DRAIN wait indefinitely.

Decomposition:
- Shared package/header (defines.vh): state encodings (3-bit localparams ST_IDLE..ST_DRAIN) and the existing FUNCT3_* constants.
- No sub-module needed. The watchdog counter stays inline under the macro.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), rd=5, busy tied to the MULDIV model -> rsp_valid_o at cycle 2, rsp_data_o=0xFFFFFFEB, rsp_rd_o=5, md_start_o high exactly 1 cycle.
- DIVU: rs1=100, rs2=7, model busy for 32 cycles -> md_start_o pulses once; rsp_data_o=14 one cycle after busy falls; req_ready_o low throughout.
- Backpressure: hold rsp_ready_i=0 for 10 cycles after DONE -> rsp_valid_o, rsp_data_o and rsp_rd_o stable; a new req_valid_i is not accepted until 1 cycle after rsp_ready_i=1.
- Flush mid-division: flush_i at WAIT cycle 5 -> DRAIN until busy falls, no rsp_valid_o, then IDLE with req_ready_o=1; a following REMU (100%7) returns 2.
- Div-by-zero: DIV rs1=0x12345678, rs2=0 -> busy stays 0, rsp_data_o=0xFFFFFFFF at cycle 2.
- Reset mid-WAIT: drop rstLow asynchronously -> immediately req_ready_o=1, rsp_valid_o=0, md_start_o=0. With MULDIV_WATCHDOG_EN and busy stuck at 1: rsp_err_o=1 and rsp_data_o=0xFFFFFFFF after 64 WAIT cycles.

Source files
------------

// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared definitions for the MULDIV issue controller: FSM state encodings and
// the RV32M funct3 codes.
package muldiv_issue_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// Sequences one M-extension op into MULDIV and returns its result over a valid/ready
// writeback handshake. Define MULDIV_WATCHDOG_EN to add the busy watchdog and rsp_err_o.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RD_WIDTH       = 5
`ifdef MULDIV_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rstLow,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_rs1_i,
    input  logic [DATA_WIDTH-1:0] req_rs2_i,
    input  logic [RD_WIDTH-1:0]   req_rd_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] md_rs1_o,
    output logic [DATA_WIDTH-1:0] md_rs2_o,
    output logic [2:0]            md_funct3_o,
    output logic                  md_start_o,
    input  logic                  md_busy_i,
    input  logic [DATA_WIDTH-1:0] md_c_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [RD_WIDTH-1:0]   rsp_rd_o,
`ifdef MULDIV_WATCHDOG_EN
    output logic                  rsp_err_o,
`endif
    output logic [DATA_WIDTH-1:0] rsp_data_o
);

    logic [2:0]            r_state;
    logic [2:0]            w_state_d;
    logic [DATA_WIDTH-1:0] r_rs1;
    logic [DATA_WIDTH-1:0] r_rs2;
    logic [2:0]            r_funct3;
    logic [RD_WIDTH-1:0]   r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_accept;
    logic                  w_capture;

`ifdef MULDIV_WATCHDOG_EN
    localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;
`endif

    // Flush in IDLE blocks acceptance, so ready is withheld to keep the handshake honest.
    assign req_ready_o = (r_state == ST_IDLE) && !flush_i;
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
`ifdef MULDIV_WATCHDOG_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_d = ST_START;
            end
            ST_START: begin
                if (flush_i) begin
                    w_state_d = md_busy_i ? ST_DRAIN : ST_IDLE;
                end else if (!md_busy_i) begin
                    w_capture = 1'b1;
                    w_state_d = ST_DONE;
                end else begin
                    w_state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    w_state_d = ST_DRAIN;
                end else if (!md_busy_i) begin
                    w_capture = 1'b1;
                    w_state_d = ST_DONE;
                end
`ifdef MULDIV_WATCHDOG_EN
                else if (r_cnt >= CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (flush_i || rsp_ready_i) w_state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // MULDIV cannot be aborted; wait for it to go idle and drop its result.
                if (!md_busy_i) w_state_d = ST_IDLE;
`ifdef MULDIV_WATCHDOG_EN
                else if (r_cnt >= CNT_LAST) w_state_d = ST_IDLE;
`endif
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_state  <= ST_IDLE;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_rs1    <= req_rs1_i;
                r_rs2    <= req_rs2_i;
                r_funct3 <= req_funct3_i;
                r_rd     <= req_rd_i;
            end
            if (w_capture) begin
                r_data <= md_c_i;
            end
`ifdef MULDIV_WATCHDOG_EN
            else if (w_timeout) begin
                r_data <= '1;
            end
`endif
        end
    end

`ifdef MULDIV_WATCHDOG_EN
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            // Cleared while in START so the count is zero on the first WAIT/DRAIN cycle.
            if (r_state == ST_START) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) || (r_state == ST_DRAIN)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_err_o = r_err;
`endif

    assign md_rs1_o    = r_rs1;
    assign md_rs2_o    = r_rs2;
    assign md_funct3_o = r_funct3;
    assign md_start_o  = (r_state == ST_START);
    assign rsp_valid_o = (r_state == ST_DONE);
    assign rsp_rd_o    = r_rd;
    assign rsp_data_o  = r_data;

endmodule
